// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mult_div_unit
//  Purpose  : MIPS-style HI/LO multiply/divide unit. Multiplies and divides
//             run for a fixed, parameterised number of busy cycles and commit
//             HI/LO on the edge where busy drops. mthi/mtlo write directly
//             when the unit is idle.
//  Options  : define MDU_MADD_EN to enable madd/maddu (accumulate into HI/LO).
//  Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // Counter only ever holds N-1 down to 1, so clog2 of the longest latency suffices.
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [3:0]       op_q;

    logic             acc_mul;
    logic             acc_div;
    logic             acc_mthi;
    logic             acc_mtlo;

    logic [63:0]      prod_s;
    logic [63:0]      prod_u;
    logic             div_signed;
    logic [31:0]      dvd;
    logic [31:0]      dvs;
    logic [31:0]      dvs_safe;
    logic [31:0]      quo_u;
    logic [31:0]      rem_u;
    logic [31:0]      quo;
    logic [31:0]      rem;
    logic [31:0]      hi_d;
    logic [31:0]      lo_d;

    // Decode a start request; only honoured while the unit is idle.
    always_comb begin
        acc_mul  = 1'b0;
        acc_div  = 1'b0;
        acc_mthi = 1'b0;
        acc_mtlo = 1'b0;
        if (start && (state_q == S_IDLE)) begin
            case (mdop)
                OP_MULT, OP_MULTU: acc_mul  = 1'b1;
                OP_DIV,  OP_DIVU:  acc_div  = 1'b1;
                OP_MTHI:           acc_mthi = 1'b1;
                OP_MTLO:           acc_mtlo = 1'b1;
`ifdef MDU_MADD_EN
                OP_MADD, OP_MADDU: acc_mul  = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    // Products from the latched operands; signed form uses sign-extended 64-bit operands.
    always_comb begin
        prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u = {32'd0, a_q} * {32'd0, b_q};
    end

    // One unsigned divider on magnitudes; signs are restored afterwards so that the
    // quotient truncates toward zero and the remainder follows the dividend.
    // Working on magnitudes also makes 0x80000000 / -1 well defined (quotient wraps).
    always_comb begin
        div_signed = (op_q == OP_DIV);
        dvd        = (div_signed && a_q[31]) ? (32'd0 - a_q) : a_q;
        dvs        = (div_signed && b_q[31]) ? (32'd0 - b_q) : b_q;
        dvs_safe   = (dvs == 32'd0) ? 32'd1 : dvs;
        quo_u      = dvd / dvs_safe;
        rem_u      = dvd % dvs_safe;
        quo        = (div_signed && (a_q[31] ^ b_q[31])) ? (32'd0 - quo_u) : quo_u;
        rem        = (div_signed && a_q[31]) ? (32'd0 - rem_u) : rem_u;
    end

    // HI/LO values to commit when the in-flight operation completes.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_DIV, OP_DIVU: begin
                // Divide by zero keeps the old HI/LO.
                if (b_q != 32'd0) begin
                    hi_d = rem;
                    lo_d = quo;
                end
            end
`ifdef MDU_MADD_EN
            OP_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
            OP_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + prod_u;
`endif
            default: ;
        endcase
    end

    // Control FSM: IDLE accepts, RUN counts down, DONE commits HI/LO and drops busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (acc_mul || acc_div) begin
                        a_q    <= A;
                        b_q    <= B;
                        op_q   <= mdop;
                        busy_q <= 1'b1;
                        cnt_q  <= acc_mul ? MULT_LOAD : DIV_LOAD;
                        // A single-cycle latency goes straight to the commit state.
                        if ((acc_mul && (MULT_CYCLES <= 1)) || (acc_div && (DIV_CYCLES <= 1))) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end else if (acc_mthi) begin
                        hi_q <= A;
                    end else if (acc_mtlo) begin
                        lo_q <= A;
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign stall_req = start | busy_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_div_unit
//  Purpose  : Self-checking bench for mult_div_unit: directed vector table,
//             hand-written multi-cycle corner sequences and a randomized run
//             compared against an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  mdop;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_hi  = 32'd0;
    logic [31:0] m_lo  = 32'd0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        int          n;
    } vec_t;

    vec_t vecs[$];

    mult_div_unit #(
        .MULT_CYCLES(MC),
        .DIV_CYCLES (DC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mdop     (mdop),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .stall_req(stall_req),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add_vec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eh, input logic [31:0] el, input int n);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.eh = eh; v.el = el; v.n = n;
        vecs.push_back(v);
    endtask

    // Reference model: architectural effect of one accepted operation.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  inout logic [31:0] h, inout logic [31:0] l, output int n);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        n  = 0;
        case (op)
            OP_MULT:  begin p = sa * sb; {h, l} = p; n = MC; end
            OP_MULTU: begin p = {32'd0, a} * {32'd0, b}; {h, l} = p; n = MC; end
            OP_DIV: begin
                n = DC;
                if (b != 32'd0) begin
                    q = sa / sb; r = sa % sb;
                    l = q[31:0]; h = r[31:0];
                end
            end
            OP_DIVU: begin
                n = DC;
                if (b != 32'd0) begin
                    l = a / b; h = a % b;
                end
            end
            OP_MTHI: h = a;
            OP_MTLO: l = a;
`ifdef MDU_MADD_EN
            OP_MADD:  begin p = {h, l} + 64'(sa * sb); {h, l} = p; n = MC; end
            OP_MADDU: begin p = {h, l} + ({32'd0, a} * {32'd0, b}); {h, l} = p; n = MC; end
`endif
            default: ;
        endcase
    endfunction

    // Issue one op for one edge, scramble the operand inputs, then measure busy and result.
    task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input int n);
        int cnt;
        @(negedge clk);
        start = 1'b1; mdop = op; A = a; B = b;
        #1 chk({nm, "_stall"}, {63'd0, stall_req}, 64'd1);
        @(negedge clk);
        start = 1'b0; A = $urandom; B = $urandom; mdop = 4'($urandom_range(0, 15));
        cnt = 0;
        while (busy && cnt < 100) begin
            chk({nm, "_hold"}, {hi, lo}, {m_hi, m_lo});
            cnt++;
            @(negedge clk);
        end
        chk({nm, "_busy_len"}, 64'(cnt), 64'(n));
        chk({nm, "_result"}, {hi, lo}, {eh, el});
        m_hi = eh; m_lo = el;
    endtask

    initial begin
        int          cnt;
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] eh;
        logic [31:0] el;
        int          n;
        int          sel;

        reset = 1'b0; start = 1'b0; mdop = OP_NONE; A = 32'd0; B = 32'd0;

        // Directed vectors, applied in order (later rows depend on earlier HI/LO).
        add_vec(OP_MULT,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, MC);
        add_vec(OP_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        DC);
        add_vec(OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC);
        add_vec(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, DC);
        add_vec(OP_MTHI,  32'h12345678, 32'd9,        32'h12345678, 32'h80000000, 0);
        add_vec(OP_MTHI,  32'hAA,       32'd0,        32'hAA,       32'h80000000, 0);
        add_vec(OP_MTLO,  32'hBB,       32'd0,        32'hAA,       32'hBB,       0);
        add_vec(OP_DIV,   32'd5,        32'd0,        32'hAA,       32'hBB,       DC);
        add_vec(OP_DIVU,  32'hFFFF,     32'd0,        32'hAA,       32'hBB,       DC);
        add_vec(OP_NONE,  32'd1,        32'd1,        32'hAA,       32'hBB,       0);
        add_vec(4'd12,    32'd1,        32'd1,        32'hAA,       32'hBB,       0);
`ifdef MDU_MADD_EN
        add_vec(OP_MADD,  32'd2,        32'd3,        32'hAA,       32'hC1,       MC);
`else
        add_vec(OP_MADD,  32'd2,        32'd3,        32'hAA,       32'hBB,       0);
        add_vec(OP_MADDU, 32'd2,        32'd3,        32'hAA,       32'hBB,       0);
`endif
        add_vec(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MC);
        add_vec(OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, DC);
        add_vec(OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        MC);

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_busy",  {63'd0, busy}, 64'd0);
        chk("rst_stall", {63'd0, stall_req}, 64'd0);
        chk("rst_hilo",  {hi, lo}, 64'd0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].eh, vecs[i].el, vecs[i].n);
        end

        // Start and mtlo while busy must both be ignored.
        @(negedge clk);
        start = 1'b1; mdop = OP_MULTU; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF;
        cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (busy) begin
                cnt++;
                chk("ign_hold", {hi, lo}, {m_hi, m_lo});
            end
            start = (i == 2) || (i == 3);
            mdop  = (i == 2) ? OP_MULT : OP_MTLO;
            A     = (i == 2) ? 32'd1 : 32'd5;
            B     = 32'd1;
        end
        start = 1'b0;
        chk("ign_busy_len", 64'(cnt), 64'(MC));
        chk("ign_result", {hi, lo}, {32'hFFFFFFFE, 32'h00000001});
        m_hi = 32'hFFFFFFFE; m_lo = 32'h00000001;

        // Asynchronous reset in the middle of a divide aborts it.
        @(negedge clk);
        start = 1'b1; mdop = OP_DIV; A = 32'd100; B = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy_before", {63'd0, busy}, 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (12) @(negedge clk);
        chk("abort_no_commit", {hi, lo}, 64'd0);
        chk("abort_idle", {63'd0, busy}, 64'd0);
        run_op("post_rst_mult", OP_MULT, 32'd3, 32'd4, 32'd0, 32'd12, MC);
`ifdef MDU_MADD_EN
        run_op("madd_mthi", OP_MTHI, 32'd0, 32'd0, 32'd0, 32'd12, 0);
        run_op("madd_mtlo", OP_MTLO, 32'd1, 32'd0, 32'd0, 32'd1, 0);
        run_op("madd_acc",  OP_MADD, 32'd2, 32'd3, 32'd0, 32'd7, MC);
`endif

        // Randomized operations against the reference model.
        for (int k = 0; k < 40; k++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0)      rb = 32'd0;
            else if (sel == 1) rb = $urandom_range(1, 9);
            else if (sel == 2) rb = 32'hFFFFFFFF;
            else               rb = $urandom;
            eh = m_hi; el = m_lo;
            model(rop, ra, rb, eh, el, n);
            run_op($sformatf("rnd%0d_op%0d", k, rop), rop, ra, rb, eh, el, n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
